// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// sevenseg_pkg : display code type, constants and builders for the scan ctl
// Rev 1.0
// ============================================================================
package sevenseg_pkg;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic       dash;
        logic [3:0] val;
    } disp_code_t;

    localparam logic [6:0] DISP_BLANK = 7'b1000000;
    localparam logic [6:0] DISP_DASH  = 7'b0010000;

    function automatic disp_code_t disp_digit(input logic [3:0] val, input logic dp);
        disp_code_t c;
        c       = '0;
        c.val   = val;
        c.dp    = dp;
        return c;
    endfunction

    function automatic disp_code_t disp_from_bits(input logic [6:0] bits);
        return disp_code_t'(bits);
    endfunction

    // A plain zero has no blank, dp or dash flag and a zero value.
    function automatic logic is_plain_zero(input disp_code_t c);
        return (c.blank == 1'b0) && (c.dp == 1'b0) && (c.dash == 1'b0) && (c.val == 4'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_lzb.sv
`default_nettype none
// ============================================================================
// sevenseg_lzb : combinational leading-zero blanker over a full frame
// Rev 1.0
// ============================================================================
module sevenseg_lzb
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS = 8
) (
    input  logic [7*NDIGITS-1:0] frame,
    input  logic                 lzb_en,
    output logic [7*NDIGITS-1:0] frame_blanked
);

    // w_run[i]: blanking is on and digits NDIGITS-1 down to i are all plain zeros
    logic [NDIGITS:1] w_run;

    assign w_run[NDIGITS] = lzb_en;

    for (genvar i = 1; i < NDIGITS; i++) begin : g_digit
        disp_code_t w_code;
        assign w_code                = disp_from_bits(frame[7*i +: 7]);
        assign w_run[i]              = w_run[i+1] & is_plain_zero(w_code);
        assign frame_blanked[7*i +: 7] = w_run[i] ? (frame[7*i +: 7] | DISP_BLANK)
                                                  : frame[7*i +: 7];
    end

    // Digit 0 always shows so an all-zero frame reads "0".
    assign frame_blanked[6:0] = frame[6:0];

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_ctl.sv
`default_nettype none
// ============================================================================
// sevenseg_scan_ctl : double-buffered multiplexed seven-segment scan controller
// Rev 1.0
// ============================================================================
module sevenseg_scan_ctl
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS     = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7*NDIGITS-1:0] digits_in,
    input  logic                 load,
    input  logic                 lzb_en,
    output logic [6:0]           d_out,
    output logic [NDIGITS-1:0]   an_n,
    output logic                 pending,
    output logic                 frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NDIGITS);
    localparam int FW = 7 * NDIGITS;

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NDIGITS - 1);
    localparam logic [FW-1:0] FRAME_BLNK = {NDIGITS{DISP_BLANK}};

    logic [CW-1:0]      r_cnt;
    logic [SW-1:0]      r_slot;
    logic [FW-1:0]      r_frame;
    logic [FW-1:0]      r_shadow;
    logic               r_wrap;

    logic               w_cnt_tc;
    logic               w_boundary;
    logic [FW-1:0]      w_blanked;
    logic [6:0]         w_sel;
    logic [NDIGITS-1:0] w_an_n;

    assign w_cnt_tc   = (r_cnt == CNT_LAST);
    assign w_boundary = w_cnt_tc && (r_slot == SLOT_LAST);

    sevenseg_lzb #(
        .NDIGITS (NDIGITS)
    ) u_lzb (
        .frame         (r_frame),
        .lzb_en        (lzb_en),
        .frame_blanked (w_blanked)
    );

    always_comb begin
        w_sel  = DISP_BLANK;
        w_an_n = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_slot == SW'(i)) begin
                w_sel     = w_blanked[7*i +: 7];
                w_an_n[i] = (r_cnt < CNT_GUARD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_slot     <= '0;
            r_frame    <= FRAME_BLNK;
            r_shadow   <= FRAME_BLNK;
            r_wrap     <= 1'b0;
            pending    <= 1'b0;
            d_out      <= DISP_BLANK;
            an_n       <= '1;
            frame_tick <= 1'b0;
        end else begin
            r_cnt <= w_cnt_tc ? '0 : r_cnt + 1'b1;
            if (w_cnt_tc) begin
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
            end

            // Frame only swaps at the boundary; a coincident load bypasses the shadow.
            if (w_boundary) begin
                if (load) begin
                    r_frame <= digits_in;
                end else if (pending) begin
                    r_frame <= r_shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                r_shadow <= digits_in;
                pending  <= 1'b1;
            end

            r_wrap     <= w_boundary;
            d_out      <= w_sel;
            an_n       <= w_an_n;
            frame_tick <= r_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctl.sv
`default_nettype none
// ============================================================================
// tb_sevenseg_scan_ctl : randomized scoreboard bench for the scan controller
// Rev 1.0
// ============================================================================
module tb_sevenseg_scan_ctl;

    localparam int ND   = 4;
    localparam int RD   = 4;
    localparam int GD   = 1;
    localparam int NCYC = 3000;

    logic          clk = 1'b1;
    logic          rst;
    logic          load;
    logic          lzb_en;
    logic [7*ND-1:0] digits_in;
    logic [6:0]    d_out;
    logic [ND-1:0] an_n;
    logic          pending;
    logic          frame_tick;

    always #5 clk = ~clk;

    sevenseg_scan_ctl #(
        .NDIGITS     (ND),
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .lzb_en     (lzb_en),
        .d_out      (d_out),
        .an_n       (an_n),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [6:0] d;
        logic [3:0] an;
        logic       tick;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: cycles since reset, displayed frame, shadow frame.
    int         m_n;
    logic [6:0] m_frame [ND];
    logic [6:0] m_shadow[ND];
    logic       m_pend;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // Code shown for digit s: blank leading plain zeros above the highest non-zero digit.
    function automatic logic [6:0] shown(input int s);
        int h;
        h = -1;
        for (int i = 0; i < ND; i++) if (m_frame[i] != 7'h00) h = i;
        if (lzb_en && s > h && s > 0) return 7'h40;
        return m_frame[s];
    endfunction

    function automatic logic [7*ND-1:0] pick_frame();
        logic [7*ND-1:0] f;
        f = '0;
        case ($urandom_range(0, 5))
            0: f = {7'h00, 7'h00, 7'h05, 7'h00};
            1: f = '0;
            2: f = {7'h20, 7'h00, 7'h00, 7'h07};
            3: f = {7'h03, 7'h02, 7'h01, 7'h00};
            default: begin
                for (int i = 0; i < ND; i++)
                    f[7*i +: 7] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom());
            end
        endcase
        return f;
    endfunction

    task automatic model_step();
        exp_t e;
        int   pos;
        int   cnt;
        int   slot;
        if (rst) begin
            e      = '{d: 7'h40, an: 4'hF, tick: 1'b0, pend: 1'b0};
            m_n    = 0;
            m_pend = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_frame[i]  = 7'h40;
                m_shadow[i] = 7'h40;
            end
        end else begin
            pos    = m_n % (ND * RD);
            cnt    = pos % RD;
            slot   = pos / RD;
            e.d    = shown(slot);
            e.an   = (cnt < GD) ? 4'hF : ~(4'b0001 << slot);
            e.tick = (pos == 0) && (m_n > 0);
            if (pos == ND * RD - 1) begin
                for (int i = 0; i < ND; i++) begin
                    if (load)        m_frame[i] = digits_in[7*i +: 7];
                    else if (m_pend) m_frame[i] = m_shadow[i];
                end
                m_pend = 1'b0;
            end else if (load) begin
                for (int i = 0; i < ND; i++) m_shadow[i] = digits_in[7*i +: 7];
                m_pend = 1'b1;
            end
            e.pend = m_pend;
            m_n++;
        end
        q.push_back(e);
    endtask

    // Monitor: compare every registered output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("d_out",      32'(d_out),      32'(e.d));
                check("an_n",       32'(an_n),       32'(e.an));
                check("frame_tick", 32'(frame_tick), 32'(e.tick));
                check("pending",    32'(pending),    32'(e.pend));
            end
        end
    end

    // Stimulus driver: randomized loads, lzb toggles and occasional resets.
    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        lzb_en    = 1'b0;
        digits_in = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst  = (c < 2) || ($urandom_range(0, 399) == 0);
            load = ($urandom_range(0, 5) == 0);
            if (load) digits_in = pick_frame();
            else      digits_in = 28'($urandom());
            if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
            model_step();
        end
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
